// File: rtl/timer_capture_buffer.sv
// ---------------------------------------------------------------------------
// timer_capture_buffer
//
// Sits downstream of the timer block. Every capture result and every alarm
// event goes into a first-word-fall-through FIFO, which is read through a
// valid/ready port. The block also tracks the running min/max of capture
// results (alarm entries are excluded). When an entry has to be dropped
// because the FIFO is full, a sticky overflow flag and a saturating drop
// counter record it.
//
// Ports:
//   clk          system clock, rising edge
//   areset_n     asynchronous active-low reset
//   sreset       synchronous clear, active high; overrides everything else
//   in_valid     one-cycle strobe: an entry is present on in_data/in_tag
//   in_data      capture count, or alarm time for alarm entries
//   in_tag       0 = capture result, 1 = alarm event
//   out_valid    FIFO head is valid
//   out_ready    consumer accepts the head
//   out_data     head data (0 while the FIFO is empty)
//   out_tag      head tag (0 while the FIFO is empty)
//   level        current occupancy, 0..DEPTH
//   full         level == DEPTH
//   overflow     sticky: at least one entry has been dropped
//   drop_cnt     number of dropped entries, saturating
//   clr_overflow clears overflow and drop_cnt
//   min_val      smallest accepted capture result (all ones if none yet)
//   max_val      largest accepted capture result (0 if none yet)
//   stats_valid  at least one capture result accepted since reset
// ---------------------------------------------------------------------------
module timer_capture_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = 8
) (
   input  logic                       clk,
   input  logic                       areset_n,
   input  logic                       sreset,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic                       out_tag,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_cnt,
   input  logic                       clr_overflow,
   output logic [DATA_W-1:0]          min_val,
   output logic [DATA_W-1:0]          max_val,
   output logic                       stats_valid
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W:0]     mem_q [DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic                overflow_q, overflow_d;
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0]   min_q, min_d;
   logic [DATA_W-1:0]   max_q, max_d;
   logic                stats_valid_q, stats_valid_d;

   logic                pop;
   logic                push;
   logic                drop;
   logic [DATA_W:0]     head;

   // The head is read combinationally from storage, which is what gives the
   // FIFO its fall-through behaviour. Data and tag are forced to zero while
   // the FIFO is empty, so stale storage never shows on the read port.
   assign out_valid   = (level_q != '0);
   assign full        = (level_q == LW'(DEPTH));
   assign head        = mem_q[rd_ptr_q];
   assign out_data    = out_valid ? head[DATA_W-1:0] : '0;
   assign out_tag     = out_valid ? head[DATA_W]     : 1'b0;
   assign level       = level_q;
   assign overflow    = overflow_q;
   assign drop_cnt    = drop_cnt_q;
   assign min_val     = min_q;
   assign max_val     = max_q;
   assign stats_valid = stats_valid_q;

   // A pop only happens when there is a head to remove. A pop in the same
   // cycle frees a slot, so a full FIFO can still accept a push; an entry is
   // dropped only when the FIFO is full and nothing leaves it.
   always_comb begin
      pop  = out_valid & out_ready;
      push = in_valid & (~full | pop);
      drop = in_valid & full & ~pop;
   end

   // Next-state computation for pointers, occupancy, overflow record and
   // statistics. The synchronous clear is handled last so that it overrides
   // any push, pop or clear in the same cycle. A drop takes priority over
   // clr_overflow, so a drop in the clearing cycle leaves a count of one.
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      overflow_d    = overflow_q;
      drop_cnt_d    = drop_cnt_q;
      min_d         = min_q;
      max_d         = max_q;
      stats_valid_d = stats_valid_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end

      if (drop) begin
         overflow_d = 1'b1;
         if (clr_overflow) begin
            drop_cnt_d = CNT_W'(1);
         end else if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
         end
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
         drop_cnt_d = '0;
      end

      if (push && !in_tag) begin
         stats_valid_d = 1'b1;
         if (in_data < min_q) begin
            min_d = in_data;
         end
         if (in_data > max_q) begin
            max_d = in_data;
         end
      end

      if (sreset) begin
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         level_d       = '0;
         overflow_d    = 1'b0;
         drop_cnt_d    = '0;
         min_d         = '1;
         max_d         = '0;
         stats_valid_d = 1'b0;
      end
   end

   // Control and statistics registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         overflow_q    <= 1'b0;
         drop_cnt_q    <= '0;
         min_q         <= '1;
         max_q         <= '0;
         stats_valid_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         overflow_q    <= overflow_d;
         drop_cnt_q    <= drop_cnt_d;
         min_q         <= min_d;
         max_q         <= max_d;
         stats_valid_q <= stats_valid_d;
      end
   end

   // Entry storage needs no reset: an entry is only visible once level says
   // it is there, and the read port is zeroed while empty.
   always_ff @(posedge clk) begin
      if (push && !sreset) begin
         mem_q[wr_ptr_q] <= {in_tag, in_data};
      end
   end

endmodule
